// File: rtl/crtc_pkg.sv
// Shared CRTC constants: address/scanline widths and the
// register-file reset values of the cursor start/end rows.
package crtc_pkg;
   localparam int ADDR_W             = 11;
   localparam int SCANLINE_W         = 4;
   localparam int CURSOR_RESET_START = 13;
   localparam int CURSOR_RESET_END   = 14;

   // Packed bundle of the CPU-domain cursor registers
   typedef struct packed {
      logic                  dis;
      logic [ADDR_W-1:0]     match;
      logic [SCANLINE_W-1:0] start;
      logic [SCANLINE_W-1:0] fin;
   } cursor_regs_t;

   localparam cursor_regs_t CURSOR_REGS_RST = '{
      dis:   1'b0,
      match: '0,
      start: SCANLINE_W'(CURSOR_RESET_START),
      fin:   SCANLINE_W'(CURSOR_RESET_END)
   };
endpackage

// File: rtl/cursor_generator_sync2.sv
// sync2: two-flop synchronizer with configurable width and reset value.
// Ports: clk, reset (async, active high), d (async input), q (synchronized).
module sync2 #(
   parameter int               W       = 1,
   parameter logic [W-1:0]     RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;
endmodule

// File: rtl/cursor_generator.sv
// cursor_generator: text-mode cursor hit detection with frame-aligned
// register shadowing, a 2-stage output pipeline and optional blinking.
// Ports: clk, reset (async high), frame_start, char_valid, char_address,
//   scanline, match_address/cursor_disable/start_scanline/end_scanline
//   (CPU domain), cursor_on (registered), blink_phase (1 = visible).
// Macro CURSOR_BLINK_EN compiles in the blink counter; without it
//   blink_phase is constant 1 and BLINK_FRAMES is ignored.
module cursor_generator
   import crtc_pkg::*;
#(
   parameter int BLINK_FRAMES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  char_valid,
   input  logic [ADDR_W-1:0]     char_address,
   input  logic [SCANLINE_W-1:0] scanline,
   input  logic [ADDR_W-1:0]     match_address,
   input  logic                  cursor_disable,
   input  logic [SCANLINE_W-1:0] start_scanline,
   input  logic [SCANLINE_W-1:0] end_scanline,
   output logic                  cursor_on,
   output logic                  blink_phase
);
   localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);

   cursor_regs_t w_regs_in;
   cursor_regs_t w_regs_sync;
   cursor_regs_t r_shadow;
   logic         w_addr_hit;
   logic         w_row_hit;
   logic         w_blink_phase;
   logic         r_hit;
   logic         r_cursor_on;

   assign w_regs_in = '{
      dis:   cursor_disable,
      match: match_address,
      start: start_scanline,
      fin:   end_scanline
   };

   sync2 #(
      .W       ($bits(cursor_regs_t)),
      .RST_VAL (CURSOR_REGS_RST)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (w_regs_in),
      .q     (w_regs_sync)
   );

   // Shadow only updates on frame_start; compare logic in that same
   // cycle still sees the previous frame's values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_shadow <= CURSOR_REGS_RST;
      else if (frame_start)
         r_shadow <= w_regs_sync;
   end

   assign w_addr_hit = (char_address == r_shadow.match);

   // start > end yields no hit: no wrap-around range
   assign w_row_hit = (r_shadow.start <= r_shadow.fin)
                    && (scanline >= r_shadow.start)
                    && (scanline <= r_shadow.fin);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit       <= 1'b0;
         r_cursor_on <= 1'b0;
      end else begin
         r_hit       <= char_valid & w_addr_hit & w_row_hit
                      & ~r_shadow.dis;
         r_cursor_on <= r_hit & w_blink_phase;
      end
   end

`ifdef CURSOR_BLINK_EN
   logic [4:0] r_blink_cnt;
   logic       r_blink_phase;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt   <= 5'd0;
         r_blink_phase <= 1'b1;
      end else if (frame_start) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= 5'd0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + 5'd1;
         end
      end
   end

   assign w_blink_phase = r_blink_phase;
`else
   logic w_unused_blink;
   assign w_unused_blink = ^BLINK_LAST;
   assign w_blink_phase  = 1'b1;
`endif

   assign cursor_on   = r_cursor_on;
   assign blink_phase = w_blink_phase;
endmodule

// File: tb/tb_cursor_generator.sv
// Directed self-checking bench for cursor_generator.
// Blink checks depend on whether CURSOR_BLINK_EN is defined.
module tb_cursor_generator;
   localparam int BF = 4;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        char_valid;
   logic [10:0] char_address;
   logic [3:0]  scanline;
   logic [10:0] match_address;
   logic        cursor_disable;
   logic [3:0]  start_scanline;
   logic [3:0]  end_scanline;
   logic        cursor_on;
   logic        blink_phase;

   int vectors;
   int miscompares;
   int m_cnt;
   logic m_phase;

   cursor_generator #(.BLINK_FRAMES(BF)) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .char_valid     (char_valid),
      .char_address   (char_address),
      .scanline       (scanline),
      .match_address  (match_address),
      .cursor_disable (cursor_disable),
      .start_scanline (start_scanline),
      .end_scanline   (end_scanline),
      .cursor_on      (cursor_on),
      .blink_phase    (blink_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sync();
      repeat (4) tick();
   endtask

   // One frame_start pulse; bench keeps its own blink model
   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
`ifdef CURSOR_BLINK_EN
      if (m_cnt == BF - 1) begin
         m_cnt   = 0;
         m_phase = ~m_phase;
      end else begin
         m_cnt = m_cnt + 1;
      end
`endif
   endtask

   // Present one cell, verify nothing at +1 cycle and result at +2
   task automatic probe(input logic [10:0] a, input logic [3:0] s,
                        input logic e, input string tag);
      char_valid   = 1'b1;
      char_address = a;
      scanline     = s;
      tick();
      char_valid = 1'b0;
      check({tag, "_lat1"}, 32'(cursor_on), 32'd0);
      tick();
      check(tag, 32'(cursor_on), 32'(e & m_phase));
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      m_cnt          = 0;
      m_phase        = 1'b1;
      reset          = 1'b1;
      frame_start    = 1'b0;
      char_valid     = 1'b0;
      char_address   = '0;
      scanline       = '0;
      match_address  = '0;
      cursor_disable = 1'b0;
      start_scanline = 4'd13;
      end_scanline   = 4'd14;
      repeat (3) tick();
      check("rst_cursor_on", 32'(cursor_on), 32'd0);
      check("rst_blink_phase", 32'(blink_phase), 32'd1);
      reset = 1'b0;
      tick();

      // Reset defaults: rows 13..14 at address 0
      frame();
      for (int s = 12; s <= 15; s++)
         probe(11'd0, 4'(s), (s == 13 || s == 14), $sformatf("def_sl%0d", s));

      // Mid-frame match change only takes effect at frame_start
      match_address = 11'h123;
      wait_sync();
      probe(11'h123, 4'd13, 1'b0, "pre_frame_new");
      probe(11'h000, 4'd13, 1'b1, "pre_frame_old");
      frame();
      probe(11'h123, 4'd13, 1'b1, "post_frame_new");
      probe(11'h000, 4'd13, 1'b0, "post_frame_old");

      // Cell in the frame_start cycle still uses old shadow
      match_address = 11'h456;
      wait_sync();
      char_valid   = 1'b1;
      char_address = 11'h456;
      scanline     = 4'd13;
      frame();
      char_valid = 1'b0;
      tick();
      check("same_cycle_old", 32'(cursor_on), 32'd0);
      probe(11'h456, 4'd13, 1'b1, "next_cycle_new");

      // Inverted range suppresses every row
      start_scanline = 4'd9;
      end_scanline   = 4'd3;
      wait_sync();
      frame();
      for (int s = 0; s < 16; s++)
         probe(11'h456, 4'(s), 1'b0, $sformatf("inv_sl%0d", s));

      // Full range 0..15 edges
      start_scanline = 4'd0;
      end_scanline   = 4'd15;
      wait_sync();
      frame();
      probe(11'h456, 4'd0, 1'b1, "full_sl0");
      probe(11'h456, 4'd15, 1'b1, "full_sl15");
      probe(11'h457, 4'd7, 1'b0, "full_addr_miss");

      // Disable
      start_scanline = 4'd13;
      end_scanline   = 4'd14;
      cursor_disable = 1'b1;
      wait_sync();
      frame();
      probe(11'h456, 4'd13, 1'b0, "disabled");
      cursor_disable = 1'b0;
      wait_sync();
      frame();
      probe(11'h456, 4'd13, 1'b1, "reenabled");

      // Async reset mid-frame kills cursor_on without a clock edge
      char_valid   = 1'b1;
      char_address = 11'h456;
      scanline     = 4'd14;
      tick();
      tick();
      check("pre_rst_on", 32'(cursor_on), 32'(m_phase));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_rst_off", 32'(cursor_on), 32'd0);
      check("async_rst_phase", 32'(blink_phase), 32'd1);
      m_cnt   = 0;
      m_phase = 1'b1;
      char_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("post_rst_glitch", 32'(cursor_on), 32'd0);
      // Shadow reset back to address 0 (registers still say 0x456)
      probe(11'h000, 4'd13, 1'b1, "post_rst_shadow");

`ifdef CURSOR_BLINK_EN
      // Blink: phase toggles every BF frames, cursor gated by phase
      for (int f = 1; f <= 12; f++) begin
         frame();
         check($sformatf("blink_f%0d", f), 32'(blink_phase),
               32'(((f / BF) % 2) == 0));
         probe(11'h456, 4'd13, 1'b1, $sformatf("blink_cur_f%0d", f));
      end
      // Counter holds with no frame_start
      repeat (20) tick();
      check("blink_hold", 32'(blink_phase), 32'(m_phase));
`else
      for (int f = 1; f <= 64; f++) begin
         frame();
         check($sformatf("noblink_f%0d", f), 32'(blink_phase), 32'd1);
      end
      probe(11'h456, 4'd13, 1'b1, "noblink_cursor");
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
